clap_light_ctrl: RTL

CLAP_LIGHT_CTRL -- requirements
Module: clap_light_ctrl

---
 rtl/clap_light_pkg.sv | 21 ++
 rtl/clap_light_ctrl_light_timer.sv | 47 ++++
 rtl/clap_light_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clap_light_pkg.sv
// Shared types for the clap-controlled light block.
//   state_t  : controller FSM states (IDLE, DECODE, APPLY, HOLDOFF)
//   action_t : decoded meaning of a latched clap count
package clap_light_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        APPLY,
        HOLDOFF
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        ALL_OFF,
        ALL_ON,
        TOGGLE,
        REJECT
    } action_t;

endpackage

// File: rtl/clap_light_ctrl_light_timer.sv
// One light flop plus its auto-off counter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   cmd_valid    : a command targets this light this cycle
//   cmd_value    : value the command writes into the light
//   light        : registered light state
// A command always overrides an expiry landing on the same edge. Turning the
// light on (including re-asserting it while already lit) restarts the count.
module light_timer #(
    parameter int AUTO_OFF_CYCLES = 0,
    parameter int TIMER_WIDTH     = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_value,
    output logic light
);

    localparam bit                     AUTO_EN = (AUTO_OFF_CYCLES > 0);
    localparam logic [TIMER_WIDTH-1:0] LAST    = TIMER_WIDTH'(AUTO_OFF_CYCLES - 1);

    function automatic logic [TIMER_WIDTH-1:0] sat_inc(input logic [TIMER_WIDTH-1:0] v);
        return (&v) ? v : v + TIMER_WIDTH'(1);
    endfunction

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            light <= 1'b0;
            count <= '0;
        end else if (cmd_valid) begin
            light <= cmd_value;
            count <= '0;
        end else if (AUTO_EN && light) begin
            // The light has been lit for AUTO_OFF_CYCLES cycles once the count
            // shows LAST, so it drops on this edge.
            if (count == LAST) begin
                light <= 1'b0;
                count <= '0;
            end else begin
                count <= sat_inc(count);
            end
        end
    end

endmodule

// File: rtl/clap_light_ctrl.sv
// Clap-count command decoder driving a bank of lights.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   claps_data    : clap count from the detector
//   claps_valid   : claps_data valid
//   claps_ready   : block accepts a word this cycle (IDLE only)
//   light_state   : registered on/off state per light
//   cmd_accepted  : one-cycle pulse, a decoded command was applied
//   cmd_rejected  : one-cycle pulse, the accepted word matched no command
//   busy          : high in every state except IDLE
// Flow: IDLE -(transfer)-> DECODE -> APPLY -> HOLDOFF (optional) -> IDLE.
// Transfer in cycle N shows up on light_state and the pulses in cycle N+3.
module clap_light_ctrl
    import clap_light_pkg::*;
#(
    parameter int CLAPS_WIDTH     = 16,
    parameter int NUM_LIGHTS      = 4,
    parameter int ALL_OFF_VAL     = 1,
    parameter int ALL_ON_VAL      = 7,
    parameter int BASE_VAL        = 2,
    parameter int HOLDOFF_CYCLES  = 1024,
    parameter int AUTO_OFF_CYCLES = 0,
    parameter int TIMER_WIDTH     = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CLAPS_WIDTH-1:0] claps_data,
    input  logic                   claps_valid,
    output logic                   claps_ready,
    output logic [NUM_LIGHTS-1:0]  light_state,
    output logic                   cmd_accepted,
    output logic                   cmd_rejected,
    output logic                   busy
);

    // Wide enough that no command constant can alias a claps_data value.
    localparam int                     XW        = CLAPS_WIDTH + 33;
    localparam logic [TIMER_WIDTH-1:0] HOLD_LAST = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);

    function automatic logic [TIMER_WIDTH-1:0] sat_inc(input logic [TIMER_WIDTH-1:0] v);
        return (&v) ? v : v + TIMER_WIDTH'(1);
    endfunction

    state_t                 state;
    state_t                 state_next;
    logic [CLAPS_WIDTH-1:0] word_p0;
    logic [XW-1:0]          word_x;
    action_t                action_dec;
    action_t                action_p1;
    logic [NUM_LIGHTS-1:0]  toggle_dec;
    logic [NUM_LIGHTS-1:0]  toggle_p1;
    logic [TIMER_WIDTH-1:0] hold_count;
    logic [NUM_LIGHTS-1:0]  light_cmd;
    logic [NUM_LIGHTS-1:0]  light_val;

    assign word_x = XW'(word_p0);

    // Priority decode of the latched word; zero never forms a command.
    always_comb begin
        toggle_dec = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (word_x == XW'(BASE_VAL) + XW'(i)) toggle_dec[i] = 1'b1;
        end
        if (word_x == '0)                        action_dec = REJECT;
        else if (word_x == XW'(ALL_OFF_VAL))     action_dec = ALL_OFF;
        else if (word_x == XW'(ALL_ON_VAL))      action_dec = ALL_ON;
        else if (|toggle_dec)                    action_dec = TOGGLE;
        else                                     action_dec = REJECT;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (claps_valid) state_next = DECODE;
            DECODE:  state_next = APPLY;
            APPLY:   state_next = (HOLDOFF_CYCLES > 0) ? HOLDOFF : IDLE;
            HOLDOFF: if (hold_count == HOLD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        claps_ready = (state == IDLE);
        busy        = (state != IDLE);
    end

    // Stage p0: word captured on transfer.
    always_ff @(posedge clock) begin
        if (state == IDLE && claps_valid) word_p0 <= claps_data;
    end

    // Stage p1: decoded action held for APPLY.
    always_ff @(posedge clock) begin
        if (state == DECODE) begin
            action_p1 <= action_dec;
            toggle_p1 <= toggle_dec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_accepted <= 1'b0;
            cmd_rejected <= 1'b0;
        end else begin
            cmd_accepted <= (state == APPLY) && (action_p1 != REJECT);
            cmd_rejected <= (state == APPLY) && (action_p1 == REJECT);
        end
    end

    // Counts cycles spent in HOLDOFF; exits on the HOLDOFF_CYCLES-th one.
    always_ff @(posedge clock) begin
        if (reset || state != HOLDOFF) hold_count <= '0;
        else                           hold_count <= sat_inc(hold_count);
    end

    // Toggle uses the light's current value, so a toggle meeting an expiry
    // on the same edge still resolves to off.
    always_comb begin
        light_cmd = '0;
        light_val = '0;
        if (state == APPLY) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                case (action_p1)
                    ALL_OFF: begin light_cmd[i] = 1'b1;         light_val[i] = 1'b0;            end
                    ALL_ON:  begin light_cmd[i] = 1'b1;         light_val[i] = 1'b1;            end
                    TOGGLE:  begin light_cmd[i] = toggle_p1[i]; light_val[i] = ~light_state[i]; end
                    default: begin light_cmd[i] = 1'b0;         light_val[i] = 1'b0;            end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_light
        light_timer #(
            .AUTO_OFF_CYCLES (AUTO_OFF_CYCLES),
            .TIMER_WIDTH     (TIMER_WIDTH)
        ) u_light_timer (
            .clock     (clock),
            .reset     (reset),
            .cmd_valid (light_cmd[g]),
            .cmd_value (light_val[g]),
            .light     (light_state[g])
        );
    end

endmodule
